reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised multi-read register file with same-cycle write bypass and a per-register
//  pending-write scoreboard. Next-generation register file for the SDLX datapath: the
//  decode stage reads rs1/rs2 here, marks each issued destination as pending, and the
//  writeback stage writes the result and clears the pending bit. Hazard detection
//  (busy_1/busy_2) uses the busy flags.
// PARAMETERS
//  DATA_W     32  register width, bits
//  ADDR_W     5   index width; NUM_REGS = 2**ADDR_W
//  ZERO_R0    1   1: R0 always reads 0, is never written, never pending
//  RESET_IDX  1   1: register i resets to value i; 0: all registers reset to 0
//  BYPASS     1   1: a write in the current cycle forwards to the read ports combinationally
// PORTS
//  clk        in   1            clock, all state updates on rising edge
//  rst        in   1            asynchronous reset, active-high
//  we         in   1            write enable (writeback)
//  rd         in   ADDR_W       write index
//  din        in   DATA_W       write data
//  rs1, rs2   in   ADDR_W       read indices
//  dout_1     out  DATA_W       read data, port 1 (combinational)
//  dout_2     out  DATA_W       read data, port 2 (combinational)
//  busy_1     out  1            rs1 has an outstanding write
//  busy_2     out  1            rs2 has an outstanding write
//  alloc_en   in   1            mark alloc_rd pending (issue)
//  alloc_rd   in   ADDR_W       index to mark pending
//  alloc_ok   out  1            alloc_rd is free: !pending[alloc_rd] (combinational)
//  pend_cnt   out  ADDR_W+1     number of registers currently pending
// BEHAVIOUR
//  - Reset (async): reg[i] = RESET_IDX ? i : 0. With ZERO_R0, reg[0] = 0. All pending bits
//    are 0; pend_cnt = 0. Outputs follow combinationally from that state.
//  - Read: dout_x = reg[rs_x]. Read latency is 0 (combinational).
//  - Read bypass: with BYPASS=1 and we && rd==rs_x (and rd!=0 when ZERO_R0), dout_x = din.
//  - R0 read: with ZERO_R0, dout_x = 0 for rs_x==0, regardless of bypass.
//  - Write: at the rising edge with we=1, reg[rd] <= din and pending[rd] <= 0.
//    - With ZERO_R0, a write to rd==0 is dropped entirely.
//    - A write to a non-pending register is legal: data is stored and pending stays 0.
//  - busy_x = pending[rs_x]. With BYPASS=1, busy_x is additionally masked to 0 when
//    we && rd==rs_x, because the data is forwarded in the same cycle.
//  - busy_x is 0 for rs_x==0 when ZERO_R0.
//  - Allocate: at the rising edge, alloc_en && alloc_ok sets pending[alloc_rd] <= 1.
//    - With alloc_en && !alloc_ok, the request is ignored; the pending state is unchanged.
//    - With ZERO_R0 and alloc_rd==0, alloc_ok=1 and the request has no effect.
//  - Simultaneous we and alloc_en, same index, index pending:
//    - alloc_ok=0, because alloc_ok uses the registered pending bit.
//    - The write stores data and clears pending; the alloc is dropped.
//    - The issue stage retries the alloc next cycle.
//  - Same case, index not pending: the write stores data, the alloc sets pending; the final
//    state is pending=1.
//  - pend_cnt is updated each edge by (+1 if an alloc takes effect) - (1 if a write clears a
//    bit that was set). Net is 0 when both occur.
//  - Invariant: pend_cnt == popcount(pending). It never exceeds NUM_REGS-ZERO_R0 and never
//    underflows.
//  - Reset asserted mid-operation: all state returns to reset values immediately. Pending
//    writes are discarded and no write completes while rst=1.
// TESTING
//  1 Reset check: default params, deassert rst, sweep rs1 over 0..31 -> dout_1==rs1 every
//    step; busy_1=0; pend_cnt=0.
//  2 Write/bypass: we=1 rd=5 din=32'hDEADBEEF rs1=5 in the same cycle -> dout_1=DEADBEEF
//    before the edge. After the edge with we=0, dout_1 still reads DEADBEEF.
//  3 R0: we=1 rd=0 din=32'hFFFF_FFFF; then alloc_en=1 alloc_rd=0 -> dout_1(rs1=0)=0,
//    busy_1=0, pend_cnt=0.
//  4 Scoreboard: alloc rd=7 -> busy_2(rs2=7)=1, pend_cnt=1, alloc_ok(7)=0. A second alloc
//    to 7 is ignored (pend_cnt=1). Then we rd=7 din=99 -> busy_2=0 in the write cycle,
//    pend_cnt=0 after.
//  5 Collision: pending[9]=1; same cycle we rd=9 and alloc_en rd=9 -> pending[9]=0 after
//    the edge, pend_cnt decremented. Repeat with pending[9]=0 -> pending[9]=1, pend_cnt
//    unchanged+1.
//  6 Async reset: alloc 3 regs, assert rst between clock edges -> pend_cnt=0 and
//    reg[4]=4 immediately, with no clock edge needed.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-read register file with same-cycle write bypass and a per-register
// pending-write scoreboard for issue/writeback hazard tracking.
module reg_file_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_R0   = 1,
  parameter int RESET_IDX = 1,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] dout_1,
  output logic [DATA_W-1:0] dout_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_rd,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                write_eff, alloc_eff, clear_eff;
  logic                r0_rs1, r0_rs2, fwd_1, fwd_2;

  // Writes and allocs aimed at a hardwired R0 are squashed here, so R0 never
  // stores data and never becomes pending.
  assign write_eff = we && !((ZERO_R0 != 0) && (rd == '0));
  assign alloc_ok  = !pend_q[alloc_rd];
  assign alloc_eff = alloc_en && alloc_ok && !((ZERO_R0 != 0) && (alloc_rd == '0));
  assign clear_eff = write_eff && pend_q[rd];

  assign r0_rs1 = (ZERO_R0 != 0) && (rs1 == '0);
  assign r0_rs2 = (ZERO_R0 != 0) && (rs2 == '0);
  assign fwd_1  = (BYPASS != 0) && write_eff && (rd == rs1);
  assign fwd_2  = (BYPASS != 0) && write_eff && (rd == rs2);

  always_comb begin
    dout_1 = regs_q[rs1];
    busy_1 = pend_q[rs1];
    if (r0_rs1) begin
      dout_1 = '0;
      busy_1 = 1'b0;
    end else if (fwd_1) begin
      dout_1 = din;
      busy_1 = 1'b0;
    end
  end

  always_comb begin
    dout_2 = regs_q[rs2];
    busy_2 = pend_q[rs2];
    if (r0_rs2) begin
      dout_2 = '0;
      busy_2 = 1'b0;
    end else if (fwd_2) begin
      dout_2 = din;
      busy_2 = 1'b0;
    end
  end

  // Clear before set: a colliding write+alloc on a free register ends pending.
  always_comb begin
    pend_d = pend_q;
    if (write_eff) pend_d[rd] = 1'b0;
    if (alloc_eff) pend_d[alloc_rd] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(alloc_eff) - (ADDR_W+1)'(clear_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (RESET_IDX != 0) ? DATA_W'(i) : '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (write_eff) regs_q[rd] <= din;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset sweep, table of single-cycle vectors
// with hand-computed results, and hand sequences for async reset.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] din;
  logic [4:0]  rs1, rs2;
  logic [31:0] dout_1, dout_2;
  logic        busy_1, busy_2;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic        alloc_ok;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .we(we), .rd(rd), .din(din),
    .rs1(rs1), .rs2(rs2), .dout_1(dout_1), .dout_2(dout_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_ok(alloc_ok),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [31:0] e_d1;
    logic        e_b1;
    logic [31:0] e_d2;
    logic        e_b2;
    logic        e_ok;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] v,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic ae, input logic [4:0] ar);
    we = w; rd = d; din = v; rs1 = a; rs2 = b; alloc_en = ae; alloc_rd = ar;
  endtask

  initial begin
    // Outputs are evaluated before the edge; the edge then commits the vector.
    vec[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd6, 1'b0, 1'b1, 6'd0};
    vec[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 1'b1, 6'd0};
    vec[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,        1'b0, 32'd0, 1'b0, 1'b1, 6'd0};
    vec[3]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 1'b1, 5'd0, 32'd0,        1'b0, 32'd1, 1'b0, 1'b1, 6'd0};
    vec[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b1, 5'd7, 32'd0,        1'b0, 32'd7, 1'b0, 1'b1, 6'd0};
    vec[5]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 1'b1, 5'd7, 32'd0,        1'b0, 32'd7, 1'b1, 1'b0, 6'd1};
    vec[6]  = '{1'b1, 5'd7, 32'd99,       5'd7, 5'd7, 1'b0, 5'd7, 32'd99,       1'b0, 32'd99, 1'b0, 1'b0, 6'd1};
    vec[7]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b0, 5'd7, 32'd99,       1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 6'd0};
    vec[8]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd9, 32'd9,        1'b0, 32'd0, 1'b0, 1'b1, 6'd0};
    vec[9]  = '{1'b1, 5'd9, 32'h123,      5'd9, 5'd9, 1'b1, 5'd9, 32'h123,      1'b0, 32'h123, 1'b0, 1'b0, 6'd1};
    vec[10] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 5'd9, 32'h123,      1'b0, 32'd0, 1'b0, 1'b1, 6'd0};
    vec[11] = '{1'b1, 5'd9, 32'h456,      5'd9, 5'd0, 1'b1, 5'd9, 32'h456,      1'b0, 32'd0, 1'b0, 1'b1, 6'd0};
    vec[12] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd9, 32'h456,      1'b1, 32'h456, 1'b1, 1'b0, 6'd1};
    vec[13] = '{1'b1, 5'd9, 32'h789,      5'd9, 5'd8, 1'b0, 5'd9, 32'h789,      1'b0, 32'd8, 1'b0, 1'b0, 6'd1};

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
    #1;
    chk("rst_hold_dout1", dout_1, 32'd4);
    chk("rst_hold_cnt", {26'd0, pend_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      chk($sformatf("sweep_dout1[%0d]", i), dout_1, 32'(i));
      chk($sformatf("sweep_busy1[%0d]", i), {31'd0, busy_1}, 32'd0);
    end
    chk("sweep_cnt", {26'd0, pend_cnt}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vec[i].we, vec[i].rd, vec[i].din, vec[i].rs1, vec[i].rs2,
            vec[i].alloc_en, vec[i].alloc_rd);
      #1;
      chk($sformatf("v%0d_dout1", i), dout_1, vec[i].e_d1);
      chk($sformatf("v%0d_busy1", i), {31'd0, busy_1}, {31'd0, vec[i].e_b1});
      chk($sformatf("v%0d_dout2", i), dout_2, vec[i].e_d2);
      chk($sformatf("v%0d_busy2", i), {31'd0, busy_2}, {31'd0, vec[i].e_b2});
      chk($sformatf("v%0d_alloc_ok", i), {31'd0, alloc_ok}, {31'd0, vec[i].e_ok});
      chk($sformatf("v%0d_cnt", i), {26'd0, pend_cnt}, {26'd0, vec[i].e_cnt});
    end

    // Async reset mid-cycle: overwrite reg 4, make 3 registers pending.
    @(negedge clk); drive(1'b1, 5'd4, 32'hAAAA, 5'd4, 5'd0, 1'b1, 5'd3);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0,    5'd4, 5'd3, 1'b1, 5'd6);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0,    5'd4, 5'd3, 1'b1, 5'd11);
    @(negedge clk); drive(1'b0, 5'd0, 32'h0,    5'd4, 5'd3, 1'b0, 5'd0);
    #1;
    chk("pre_rst_cnt", {26'd0, pend_cnt}, 32'd3);
    chk("pre_rst_dout1", dout_1, 32'hAAAA);
    chk("pre_rst_busy2", {31'd0, busy_2}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cnt", {26'd0, pend_cnt}, 32'd0);
    chk("async_rst_dout1", dout_1, 32'd4);
    chk("async_rst_busy2", {31'd0, busy_2}, 32'd0);

    // A write held across an edge during reset must not land.
    drive(1'b1, 5'd4, 32'hBBBB, 5'd4, 5'd3, 1'b1, 5'd3);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    chk("rst_write_dropped", dout_1, 32'd4);
    chk("rst_alloc_dropped", {26'd0, pend_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
